example_sched: RTL and testbench

EXAMPLE_SCHED -- requirements
Module: example_sched

---
 rtl/example_sched.sv | 108 ++++++++++
 tb/tb_example_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/example_sched.sv
// Job scheduler: arbitrates requesters onto a shared 3-flop XOR datapath,
// sequences the operands through it and checks the result against their parity.
module example_sched #(
   parameter int NREQ       = 3,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [NREQ-1:0] req_i,
   input  logic [NREQ-1:0] req_s1_i,
   input  logic [NREQ-1:0] req_s2_i,
   input  logic [NREQ-1:0] req_r_i,
   output logic [NREQ-1:0] grant_o,
   output logic [NREQ-1:0] done_o,
   output logic            result_o,
   output logic            mismatch_o,
   output logic [7:0]      err_cnt_o,
   output logic            dp_s1_o,
   output logic            dp_s2_o,
   output logic            dp_r_o,
   output logic            dp_rst_o,
   input  logic            dp_o_i
);

   localparam int IW = $clog2(NREQ);

   typedef enum logic [2:0] {IDLE, PH1, PH2, CAP, DONE} state_t;

   state_t        state;
   logic [IW-1:0] last_winner;
   logic [IW-1:0] pick;
   logic          s1_q, s2_q, r_q;
   logic          mismatch;

   // Candidates are visited from lowest to highest priority so the last hit wins.
   function automatic logic [IW-1:0] arbitrate(input logic [NREQ-1:0] req,
                                               input logic [IW-1:0]   last);
      logic [IW-1:0] sel;
      logic [IW-1:0] cand;
      int            idx;
      sel = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = FIXED_PRIO ? i - 1 : int'(last) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = IW'(idx);
         if (req[cand]) sel = cand;
      end
      return sel;
   endfunction

   always_comb begin
      pick = arbitrate(req_i, last_winner);
   end

   assign mismatch = dp_o_i ^ (s1_q ^ s2_q ^ r_q);

   // Datapath drives are pure decodes of the registered state and latched operands.
   assign dp_rst_o = (state == IDLE);
   assign dp_s1_o  = (state == PH1) & s1_q;
   assign dp_s2_o  = (state == PH2) & s2_q;
   assign dp_r_o   = (state == PH2) & r_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         grant_o     <= '0;
         done_o      <= '0;
         result_o    <= 1'b0;
         mismatch_o  <= 1'b0;
         err_cnt_o   <= '0;
         last_winner <= IW'(NREQ - 1);
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         r_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every branch sees pre-edge state.
         case (state)
            IDLE: begin
               if (|req_i) begin
                  last_winner <= pick;
                  grant_o     <= NREQ'(1) << pick;
                  s1_q        <= req_s1_i[pick];
                  s2_q        <= req_s2_i[pick];
                  r_q         <= req_r_i[pick];
                  state       <= PH1;
               end
            end
            PH1: state <= PH2;
            PH2: state <= CAP;
            CAP: begin
               result_o   <= dp_o_i;
               mismatch_o <= mismatch;
               done_o     <= grant_o;
               if (mismatch && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
               state      <= DONE;
            end
            DONE: begin
               done_o     <= '0;
               mismatch_o <= 1'b0;
               grant_o    <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_example_sched.sv
// Randomized self-checking bench for example_sched: a round-robin and a
// fixed-priority instance, each closed through a behavioural XOR datapath.
`timescale 1ns/1ps
module tb_example_sched;

   localparam int NREQ = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NREQ-1:0] req_rr, req_fp, s1, s2, r;
   logic [NREQ-1:0] grant_rr, done_rr, grant_fp, done_fp;
   logic            result_rr, mism_rr, result_fp, mism_fp;
   logic [7:0]      err_rr, err_fp;
   logic            ds1_rr, ds2_rr, dr_rr, drst_rr, do_rr;
   logic            ds1_fp, ds2_fp, dr_fp, drst_fp, do_fp;
   logic            fault;
   logic [2:0]      ff_rr, ff_fp;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_rr;
   int err_model;

   always @(posedge clk) cyc <= cyc + 1;

   example_sched #(.NREQ(NREQ), .FIXED_PRIO(1'b0)) u_rr (
      .clk_i(clk), .rst_i(rst), .req_i(req_rr),
      .req_s1_i(s1), .req_s2_i(s2), .req_r_i(r),
      .grant_o(grant_rr), .done_o(done_rr), .result_o(result_rr),
      .mismatch_o(mism_rr), .err_cnt_o(err_rr),
      .dp_s1_o(ds1_rr), .dp_s2_o(ds2_rr), .dp_r_o(dr_rr),
      .dp_rst_o(drst_rr), .dp_o_i(do_rr)
   );

   example_sched #(.NREQ(NREQ), .FIXED_PRIO(1'b1)) u_fp (
      .clk_i(clk), .rst_i(rst), .req_i(req_fp),
      .req_s1_i(s1), .req_s2_i(s2), .req_r_i(r),
      .grant_o(grant_fp), .done_o(done_fp), .result_o(result_fp),
      .mismatch_o(mism_fp), .err_cnt_o(err_fp),
      .dp_s1_o(ds1_fp), .dp_s2_o(ds2_fp), .dp_r_o(dr_fp),
      .dp_rst_o(drst_fp), .dp_o_i(do_fp)
   );

   // Shared datapath: three toggle flops with synchronous reset, output is their XOR.
   always_ff @(posedge clk) begin
      if (drst_rr) ff_rr <= '0;
      else         ff_rr <= ff_rr ^ {dr_rr, ds2_rr, ds1_rr};
      if (drst_fp) ff_fp <= '0;
      else         ff_fp <= ff_fp ^ {dr_fp, ds2_fp, ds1_fp};
   end
   assign do_rr = fault | (^ff_rr);
   assign do_fp = ^ff_fp;

   // Winner prediction straight from the arbitration rules.
   function automatic int model_pick(input logic [NREQ-1:0] req, input bit fixed, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = fixed ? k - 1 : (last + k) % NREQ;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic scramble_ops();
      s1 = 3'($urandom);
      s2 = 3'($urandom);
      r  = 3'($urandom);
   endtask

   task automatic reset_dut();
      req_rr = '0;
      req_fp = '0;
      fault  = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      last_rr   = NREQ - 1;
      err_model = 0;
   endtask

   task automatic test_reset();
      req_rr = '1; req_fp = '1; fault = 1'b0;
      s1 = '0; s2 = '0; r = '0;
      #3 rst = 1'b1;
      #1;
      n_checks++; if ({grant_rr, done_rr, result_rr, mism_rr} !== 8'h00) begin n_fail++;
         $display("FAIL reset.outs_rr: got %b expected 00000000", {grant_rr, done_rr, result_rr, mism_rr}); end
      n_checks++; if (err_rr !== 8'd0) begin n_fail++; $display("FAIL reset.err_rr: got %0d expected 0", err_rr); end
      n_checks++; if ({drst_rr, ds1_rr, ds2_rr, dr_rr} !== 4'b1000) begin n_fail++;
         $display("FAIL reset.dp_rr: got %b expected 1000", {drst_rr, ds1_rr, ds2_rr, dr_rr}); end
      n_checks++; if ({grant_fp, done_fp, result_fp, mism_fp, err_fp, drst_fp, ds1_fp, ds2_fp, dr_fp} !== 20'h00008) begin
         n_fail++; $display("FAIL reset.outs_fp: got %h expected 00008",
                            {grant_fp, done_fp, result_fp, mism_fp, err_fp, drst_fp, ds1_fp, ds2_fp, dr_fp}); end
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if ({grant_rr, grant_fp} !== 6'b0) begin n_fail++;
         $display("FAIL reset.grant_held: got %b expected 000000", {grant_rr, grant_fp}); end
      @(negedge clk);
      req_rr = '0; req_fp = '0;
      rst = 1'b0;
      last_rr = NREQ - 1; err_model = 0;
   endtask

   task automatic test_single_job();
      logic [NREQ-1:0] exp_done;
      req_rr = 3'b001; s1 = 3'b001; s2 = 3'b000; r = 3'b001;
      @(negedge clk);
      req_rr = '0;
      last_rr = 0;
      for (int c = 1; c <= 4; c++) begin
         exp_done = (c == 4) ? 3'b001 : 3'b000;
         n_checks++; if (grant_rr !== 3'b001) begin n_fail++;
            $display("FAIL single.grant c%0d: got %b expected 001", c, grant_rr); end
         n_checks++; if (done_rr !== exp_done) begin n_fail++;
            $display("FAIL single.done c%0d: got %b expected %b", c, done_rr, exp_done); end
         if (c == 1) begin
            n_checks++; if ({drst_rr, ds1_rr, ds2_rr, dr_rr} !== 4'b0100) begin n_fail++;
               $display("FAIL single.ph1_dp: got %b expected 0100", {drst_rr, ds1_rr, ds2_rr, dr_rr}); end
         end
         if (c == 4) begin
            n_checks++; if ({result_rr, mism_rr} !== 2'b00) begin n_fail++;
               $display("FAIL single.result: got %b expected 00", {result_rr, mism_rr}); end
         end
         if (c < 4) @(negedge clk);
      end
      @(negedge clk);
      n_checks++; if ({grant_rr, done_rr} !== 6'b0) begin n_fail++;
         $display("FAIL single.idle: got %b expected 000000", {grant_rr, done_rr}); end
   endtask

   task automatic test_round_robin();
      int   exp_w;
      int   last_done;
      logic exp_res;
      reset_dut();
      req_rr = '1;
      last_done = -1;
      for (int j = 0; j < 4; j++) begin
         scramble_ops();
         exp_w   = model_pick(req_rr, 1'b0, last_rr);
         last_rr = exp_w;
         exp_res = s1[exp_w] ^ s2[exp_w] ^ r[exp_w];
         @(negedge clk); scramble_ops();
         n_checks++; if (grant_rr !== 3'(3'b001 << exp_w)) begin n_fail++;
            $display("FAIL rr.grant j%0d: got %b expected %b", j, grant_rr, 3'(3'b001 << exp_w)); end
         repeat (3) begin @(negedge clk); scramble_ops(); end
         n_checks++; if (done_rr !== 3'(3'b001 << exp_w)) begin n_fail++;
            $display("FAIL rr.done j%0d: got %b expected %b", j, done_rr, 3'(3'b001 << exp_w)); end
         n_checks++; if ({result_rr, mism_rr} !== {exp_res, 1'b0}) begin n_fail++;
            $display("FAIL rr.result j%0d: got %b expected %b", j, {result_rr, mism_rr}, {exp_res, 1'b0}); end
         if (j > 0) begin
            n_checks++; if (cyc - last_done != 5) begin n_fail++;
               $display("FAIL rr.spacing j%0d: got %0d expected 5", j, cyc - last_done); end
         end
         last_done = cyc;
         @(negedge clk);
      end
      req_rr = '0;
   endtask

   task automatic test_fixed_prio();
      int   exp_w;
      logic exp_res;
      req_fp = 3'b110;
      for (int j = 0; j < 3; j++) begin
         scramble_ops();
         exp_w   = model_pick(req_fp, 1'b1, 0);
         exp_res = s1[exp_w] ^ s2[exp_w] ^ r[exp_w];
         @(negedge clk); scramble_ops();
         n_checks++; if (grant_fp !== 3'(3'b001 << exp_w)) begin n_fail++;
            $display("FAIL fp.grant j%0d: got %b expected %b", j, grant_fp, 3'(3'b001 << exp_w)); end
         repeat (3) begin @(negedge clk); scramble_ops(); end
         n_checks++; if ({done_fp, result_fp, mism_fp} !== {3'(3'b001 << exp_w), exp_res, 1'b0}) begin n_fail++;
            $display("FAIL fp.done j%0d: got %b expected %b", j, {done_fp, result_fp, mism_fp},
                     {3'(3'b001 << exp_w), exp_res, 1'b0}); end
         @(negedge clk);
      end
      req_fp = '0;
   endtask

   task automatic test_fault();
      int pulses;
      reset_dut();
      s1 = '0; s2 = '0; r = '0;
      fault = 1'b1;
      req_rr = 3'b001;
      repeat (4) @(negedge clk);
      n_checks++; if ({result_rr, mism_rr, err_rr} !== {1'b1, 1'b1, 8'd1}) begin n_fail++;
         $display("FAIL fault.first: got res=%b mis=%b err=%0d expected res=1 mis=1 err=1", result_rr, mism_rr, err_rr); end
      pulses = 1;
      for (int k = 0; k < 299 * 5; k++) begin
         @(negedge clk);
         if (mism_rr) pulses++;
      end
      n_checks++; if (pulses != 300) begin n_fail++;
         $display("FAIL fault.pulses: got %0d expected 300", pulses); end
      n_checks++; if (err_rr !== 8'd255) begin n_fail++;
         $display("FAIL fault.saturate: got %0d expected 255", err_rr); end
      req_rr = '0; fault = 1'b0;
      @(negedge clk);
      n_checks++; if ({mism_rr, err_rr} !== {1'b0, 8'd255}) begin n_fail++;
         $display("FAIL fault.hold: got mis=%b err=%0d expected mis=0 err=255", mism_rr, err_rr); end
      last_rr = 0; err_model = 255;
   endtask

   task automatic test_reset_mid_job();
      int   exp_w;
      logic exp_res;
      scramble_ops();
      req_rr = 3'b011;
      @(negedge clk);
      req_rr = '0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({grant_rr, done_rr, result_rr, mism_rr, err_rr} !== 16'h0000) begin n_fail++;
         $display("FAIL midrst.outs: got %h expected 0000", {grant_rr, done_rr, result_rr, mism_rr, err_rr}); end
      n_checks++; if ({drst_rr, ds1_rr, ds2_rr, dr_rr} !== 4'b1000) begin n_fail++;
         $display("FAIL midrst.dp: got %b expected 1000", {drst_rr, ds1_rr, ds2_rr, dr_rr}); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++; if ({grant_rr, done_rr} !== 6'b0) begin n_fail++;
            $display("FAIL midrst.no_done k%0d: got %b expected 000000", k, {grant_rr, done_rr}); end
      end
      scramble_ops();
      req_rr = 3'b100;
      rst = 1'b0;
      last_rr = NREQ - 1; err_model = 0;
      exp_w   = model_pick(req_rr, 1'b0, last_rr);
      last_rr = exp_w;
      exp_res = s1[exp_w] ^ s2[exp_w] ^ r[exp_w];
      @(negedge clk);
      req_rr = '0;
      n_checks++; if ({grant_rr, done_rr} !== {3'(3'b001 << exp_w), 3'b000}) begin n_fail++;
         $display("FAIL midrst.grant: got %b expected %b", {grant_rr, done_rr}, {3'(3'b001 << exp_w), 3'b000}); end
      repeat (3) @(negedge clk);
      n_checks++; if ({done_rr, result_rr} !== {3'(3'b001 << exp_w), exp_res}) begin n_fail++;
         $display("FAIL midrst.done: got %b expected %b", {done_rr, result_rr}, {3'(3'b001 << exp_w), exp_res}); end
      @(negedge clk);
   endtask

   task automatic test_withdraw();
      int exp_w;
      scramble_ops();
      req_rr  = 3'b001;
      exp_w   = model_pick(req_rr, 1'b0, last_rr);
      last_rr = exp_w;
      @(negedge clk);
      req_rr = 3'b010;
      @(negedge clk);
      req_rr = 3'b000;
      repeat (2) @(negedge clk);
      n_checks++; if (done_rr !== 3'(3'b001 << exp_w)) begin n_fail++;
         $display("FAIL withdraw.done: got %b expected %b", done_rr, 3'(3'b001 << exp_w)); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++; if (grant_rr !== 3'b000) begin n_fail++;
            $display("FAIL withdraw.no_grant k%0d: got %b expected 000", k, grant_rr); end
      end
   endtask

   task automatic test_random();
      for (int j = 0; j < 40; j++) begin
         int   wr, wf;
         logic er, ef, exp_mis, exp_result;
         logic s1w, s2w, rw;
         req_rr = 3'($urandom_range(1, 7));
         req_fp = 3'($urandom_range(1, 7));
         fault  = ($urandom_range(0, 3) == 0);
         scramble_ops();
         wr = model_pick(req_rr, 1'b0, last_rr);
         last_rr = wr;
         wf = model_pick(req_fp, 1'b1, 0);
         s1w = s1[wr]; s2w = s2[wr]; rw = r[wr];
         er = s1w ^ s2w ^ rw;
         ef = s1[wf] ^ s2[wf] ^ r[wf];
         exp_result = fault ? 1'b1 : er;
         exp_mis    = exp_result ^ er;
         if (exp_mis && err_model < 255) err_model++;
         @(negedge clk);
         n_checks++; if ({grant_rr, grant_fp} !== {3'(3'b001 << wr), 3'(3'b001 << wf)}) begin n_fail++;
            $display("FAIL rand.grant j%0d: got %b expected %b", j, {grant_rr, grant_fp},
                     {3'(3'b001 << wr), 3'(3'b001 << wf)}); end
         n_checks++; if ({ds1_rr, ds2_rr, dr_rr} !== {s1w, 2'b00}) begin n_fail++;
            $display("FAIL rand.ph1 j%0d: got %b expected %b", j, {ds1_rr, ds2_rr, dr_rr}, {s1w, 2'b00}); end
         req_rr = 3'($urandom); req_fp = 3'($urandom); scramble_ops();
         @(negedge clk);
         n_checks++; if ({ds1_rr, ds2_rr, dr_rr} !== {1'b0, s2w, rw}) begin n_fail++;
            $display("FAIL rand.ph2 j%0d: got %b expected %b", j, {ds1_rr, ds2_rr, dr_rr}, {1'b0, s2w, rw}); end
         req_rr = 3'($urandom); req_fp = 3'($urandom); scramble_ops();
         repeat (2) @(negedge clk);
         n_checks++; if ({done_rr, result_rr, mism_rr, err_rr} !== {3'(3'b001 << wr), exp_result, exp_mis, 8'(err_model)}) begin
            n_fail++; $display("FAIL rand.done_rr j%0d: got %b expected %b", j, {done_rr, result_rr, mism_rr, err_rr},
                               {3'(3'b001 << wr), exp_result, exp_mis, 8'(err_model)}); end
         n_checks++; if ({done_fp, result_fp, mism_fp, err_fp} !== {3'(3'b001 << wf), ef, 1'b0, 8'd0}) begin
            n_fail++; $display("FAIL rand.done_fp j%0d: got %b expected %b", j, {done_fp, result_fp, mism_fp, err_fp},
                               {3'(3'b001 << wf), ef, 1'b0, 8'd0}); end
         @(negedge clk);
         n_checks++; if ({grant_rr, done_rr, mism_rr, result_rr} !== {6'b0, 1'b0, exp_result}) begin n_fail++;
            $display("FAIL rand.idle j%0d: got %b expected %b", j, {grant_rr, done_rr, mism_rr, result_rr},
                     {6'b0, 1'b0, exp_result}); end
      end
      req_rr = '0; req_fp = '0; fault = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_job();
      test_round_robin();
      test_fixed_prio();
      test_fault();
      test_reset_mid_job();
      test_withdraw();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
